// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and KMP next-state helpers for the serial pattern detector
package seq_det_pkg;

    // Default pattern: 1011, first bit received is bit LEN-1
    localparam int         LEN     = 4;
    localparam logic [3:0] PATTERN = 4'b1011;

    // Widest pattern the helpers handle; callers zero-extend shorter patterns
    localparam int MAX_LEN = 16;

    // Longest proper suffix of the pattern that is also a prefix of it.
    // Pattern bit len-1 is the first bit in time, bit 0 the last.
    function automatic int overlap_len(input logic [MAX_LEN-1:0] pattern, input int len);
        int   best;
        logic ok;
        best = 0;
        for (int m = 1; m < MAX_LEN; m++) begin
            if (m < len) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_LEN; j++) begin
                    if (j < m) begin
                        if (pattern[4'(m - 1 - j)] != pattern[4'(len - 1 - j)]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = m;
                end
            end
        end
        return best;
    endfunction

    // Next matched-prefix length after appending in_bit to a prefix of length state.
    // A completed match falls back to the pattern's self-overlap so detections can chain.
    function automatic int next_match(input logic [MAX_LEN-1:0] pattern, input int len,
                                      input int state, input logic in_bit);
        logic [MAX_LEN-1:0] cand;
        int                 k;
        int                 best;
        logic               ok;
        if ((state == len - 1) && (in_bit == pattern[0])) begin
            return overlap_len(pattern, len);
        end
        // cand[i] holds the i-th received bit of the candidate, oldest first
        cand = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < state) begin
                cand[4'(i)] = pattern[4'(len - 1 - i)];
            end
        end
        cand[4'(state)] = in_bit;
        k    = state + 1;
        best = 0;
        for (int m = 1; m < MAX_LEN; m++) begin
            if ((m <= k) && (m < len)) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_LEN; j++) begin
                    if (j < m) begin
                        if (cand[4'(k - m + j)] != pattern[4'(len - 1 - j)]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = m;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detector_mealy.sv
// rtl/seq_detector_mealy.sv - overlapping Mealy serial pattern detector
module seq_detector_mealy #(
    parameter int             LEN     = seq_det_pkg::LEN,
    parameter logic [LEN-1:0] PATTERN = seq_det_pkg::PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic z
);
    import seq_det_pkg::*;

    // State is the number of pattern bits matched so far (0..LEN-1)
    localparam int SW  = (LEN > 2) ? $clog2(LEN) : 1;
    localparam int TBL = 2 ** (SW + 1);

    logic [SW-1:0] r_state;
    logic [SW:0]   w_idx;
    logic [SW-1:0] w_next_tbl [TBL];

    // Transition table indexed by {state, x}; encodings past LEN-1 map back to 0
    for (genvar g = 0; g < TBL; g++) begin : g_tbl
        if ((g / 2) < LEN) begin : g_live
            assign w_next_tbl[g] = SW'(next_match(16'(PATTERN), LEN, g / 2, 1'((g % 2) == 1)));
        end else begin : g_dead
            assign w_next_tbl[g] = '0;
        end
    end

    assign w_idx = {r_state, x};

    // Advance the matched-prefix count; reset discards any partial match
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= '0;
        end else begin
            r_state <= w_next_tbl[w_idx];
        end
    end

    // Detect in the same cycle as the final bit, suppressed while reset is low
    assign z = (r_state == SW'(LEN - 1)) && (x == PATTERN[0]) && reset;

endmodule

// File: tb/tb_seq_detector_mealy.sv
// tb/tb_seq_detector_mealy.sv - self-checking bench for seq_detector_mealy
module tb_seq_detector_mealy;

    logic clk;
    logic reset;
    logic x;
    logic z0;
    logic z1;
    logic z2;

    int n_checks;
    int n_errors;
    int n_steps;

    // Reference history: bits received since the last reset, newest in bit 0
    logic [15:0] m_hist;
    int          m_nbits;

    typedef struct {
        logic x;
        logic rst;
        logic ez;
    } vec_t;

    vec_t tbl [18];

    seq_detector_mealy #(.LEN(4), .PATTERN(4'b1011)) dut0 (
        .clk(clk), .reset(reset), .x(x), .z(z0)
    );
    seq_detector_mealy #(.LEN(4), .PATTERN(4'b1111)) dut1 (
        .clk(clk), .reset(reset), .x(x), .z(z1)
    );
    seq_detector_mealy #(.LEN(3), .PATTERN(3'b010)) dut2 (
        .clk(clk), .reset(reset), .x(x), .z(z2)
    );

    always #5 clk = ~clk;

    // A detection happens whenever the last len bits (including the current one) equal the pattern
    function automatic logic model_z(input int len, input logic [15:0] pat, input logic xb, input logic rb);
        logic [15:0] win;
        logic [15:0] mask;
        win  = {m_hist[14:0], xb};
        mask = 16'((32'd1 << len) - 1);
        return rb && (m_nbits >= len - 1) && ((win & mask) == pat);
    endfunction

    task automatic model_edge(input logic xb, input logic rb);
        if (!rb) begin
            m_hist  = '0;
            m_nbits = 0;
        end else begin
            m_hist  = {m_hist[14:0], xb};
            m_nbits = m_nbits + 1;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: z=%0b expected %0b", name, n_steps, act, exp);
        end
    endtask

    function automatic int ez(input string s, input int i);
        if (i >= s.len()) return -1;
        return (s[i] == "1") ? 1 : 0;
    endfunction

    task automatic step(input string name, input logic xb, input logic rb,
                        input int e0, input int e1, input int e2);
        @(negedge clk);
        x     = xb;
        reset = rb;
        #1;
        chk({name, "_ref1011"}, z0, model_z(4, 16'h000B, xb, rb));
        chk({name, "_ref1111"}, z1, model_z(4, 16'h000F, xb, rb));
        chk({name, "_ref010"},  z2, model_z(3, 16'h0002, xb, rb));
        if (e0 >= 0) chk({name, "_1011"}, z0, e0[0]);
        if (e1 >= 0) chk({name, "_1111"}, z1, e1[0]);
        if (e2 >= 0) chk({name, "_010"},  z2, e2[0]);
        @(posedge clk);
        model_edge(xb, rb);
        n_steps++;
    endtask

    task automatic seq(input string name, input string bits,
                       input string s0, input string s1, input string s2);
        for (int i = 0; i < bits.len(); i++) begin
            step(name, bits[i] == "1", 1'b1, ez(s0, i), ez(s1, i), ez(s2, i));
        end
    endtask

    task automatic rst2();
        step("rst", 1'b1, 1'b0, 0, 0, 0);
        step("rst", 1'b1, 1'b0, 0, 0, 0);
    endtask

    initial begin
        string sbits;
        string sexp;
        clk      = 1'b0;
        x        = 1'b0;
        reset    = 1'b0;
        m_hist   = '0;
        m_nbits  = 0;
        n_checks = 0;
        n_errors = 0;
        n_steps  = 0;

        // Table: two reset edges with x=1, then the long stream with detections on bits 6, 9, 15
        sbits  = "0010110110010110";
        sexp   = "0000010010000010";
        tbl[0] = '{x: 1'b1, rst: 1'b0, ez: 1'b0};
        tbl[1] = '{x: 1'b1, rst: 1'b0, ez: 1'b0};
        for (int i = 0; i < 16; i++) begin
            tbl[i + 2] = '{x: (sbits[i] == "1"), rst: 1'b1, ez: (sexp[i] == "1")};
        end
        for (int i = 0; i < 18; i++) begin
            step("table", tbl[i].x, tbl[i].rst, int'(tbl[i].ez), -1, -1);
        end

        // First bit after release starts from IDLE, not from a reset-time prefix
        rst2();
        seq("post_rst", "011", "000", "", "");

        rst2();
        seq("overlap", "1011011", "0001001", "", "");

        rst2();
        seq("nonmatch", "1001", "0000", "", "");

        // Reset in the middle of a partial match
        rst2();
        seq("mid_a", "101", "000", "", "");
        step("mid_rst", 1'b1, 1'b0, 0, 0, 0);
        seq("mid_b", "1011", "0001", "", "");

        // In S3, z tracks x combinationally within one cycle
        rst2();
        seq("comb_pre", "101", "000", "", "");
        @(negedge clk);
        reset = 1'b1;
        x     = 1'b0;
        #1 chk("comb_x0", z0, 1'b0);
        x = 1'b1;
        #1 chk("comb_x1", z0, 1'b1);
        x = 1'b0;
        #1 chk("comb_x0_again", z0, 1'b0);
        @(posedge clk);
        model_edge(1'b0, 1'b1);
        n_steps++;

        rst2();
        seq("sweep1111", "111111", "", "000111", "");
        rst2();
        seq("sweep010", "01010", "", "", "00101");

        // Random stream with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 31) != 0), -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
